// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between the CPU sequencer and the rest of the
// single-datapath CPU (decoder, instruction register, register file, dmem).
interface cpu_sequencer_if #(
  parameter int PC_WIDTH = 9
);
  // Inputs to the sequencer
  logic                run;
  logic [5:0]          opcode;
  logic                rfWriteEnDec;
  logic                dmemResultSel;
  logic                dmemWriteDec;
  logic                branch;
  logic [PC_WIDTH-1:0] pcDest;

  // Outputs from the sequencer
  logic [PC_WIDTH-1:0] pc;
  logic                irLoad;
  logic                rfWriteEn;
  logic                dmemWriteEn;
  logic [2:0]          phase;
  logic                halted;
  logic [15:0]         retired;

  // Sequencer side: owns pc, strobes and status.
  modport master (
    input  run, opcode, rfWriteEnDec, dmemResultSel, dmemWriteDec, branch, pcDest,
    output pc, irLoad, rfWriteEn, dmemWriteEn, phase, halted, retired
  );

  // Datapath/decoder side: supplies decode levels, consumes strobes.
  modport slave (
    output run, opcode, rfWriteEnDec, dmemResultSel, dmemWriteDec, branch, pcDest,
    input  pc, irLoad, rfWriteEn, dmemWriteEn, phase, halted, retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the single-datapath CPU. Steps one instruction
// at a time through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, owns the program
// counter and retired-instruction counter, and turns the decoder's level
// controls into one-cycle commit strobes.
module cpu_sequencer #(
  parameter int         PC_WIDTH = 9,
  parameter int         MEM_WAIT = 1,
  parameter logic [5:0] HALT_OP  = 6'b111111
) (
  input logic             clk,
  input logic             rst,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    st_idle      = 3'd0,
    st_fetch     = 3'd1,
    st_decode    = 3'd2,
    st_execute   = 3'd3,
    st_memory    = 3'd4,
    st_writeback = 3'd5,
    st_halt      = 3'd6
  } state_e;

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         retired_q, retired_d;
  logic [2:0]          wait_q, wait_d;
  logic                complete;

  // State register: synchronous reset has priority over every transition.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q   <= st_idle;
      pc_q      <= '0;
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  // Next-state, pc update and instruction-completion logic.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // the case statement leaves one unassigned (which would infer a latch).
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    wait_d    = wait_q;
    complete  = 1'b0;

    unique case (state_q)
      st_idle: begin
        if (bus.run) state_d = st_fetch;
      end
      st_fetch: begin
        state_d = st_decode;
      end
      st_decode: begin
        state_d = (bus.opcode == HALT_OP) ? st_halt : st_execute;
      end
      st_execute: begin
        // Branch beats memory, memory beats writeback.
        if (bus.branch) begin
          pc_d     = bus.pcDest;
          complete = 1'b1;
        end else if (bus.dmemResultSel || bus.dmemWriteDec) begin
          state_d = st_memory;
          wait_d  = WAIT_INIT;
        end else if (bus.rfWriteEnDec) begin
          state_d = st_writeback;
        end else begin
          pc_d     = pc_q + PC_WIDTH'(1);
          complete = 1'b1;
        end
      end
      st_memory: begin
        if (wait_q != 3'd0) begin
          wait_d = wait_q - 3'd1;
        end else if (bus.dmemResultSel) begin
          state_d = st_writeback;
        end else begin
          pc_d     = pc_q + PC_WIDTH'(1);
          complete = 1'b1;
        end
      end
      st_writeback: begin
        pc_d     = pc_q + PC_WIDTH'(1);
        complete = 1'b1;
      end
      st_halt: begin
        state_d = st_halt;
      end
      default: begin
        state_d = st_idle;
      end
    endcase

    // Instruction boundary: count it and decide whether to keep running.
    if (complete) begin
      if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
      state_d = bus.run ? st_fetch : st_idle;
    end
  end

  // Moore strobes decoded from the state register.
  assign bus.pc          = pc_q;
  assign bus.retired     = retired_q;
  assign bus.phase       = state_q;
  assign bus.irLoad      = (state_q == st_fetch);
  assign bus.rfWriteEn   = (state_q == st_writeback);
  assign bus.halted      = (state_q == st_halt);
  // The counter still equals its load value only on the first MEMORY cycle.
  assign bus.dmemWriteEn = (state_q == st_memory) && (wait_q == WAIT_INIT) && bus.dmemWriteDec;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: directed instruction sequences; the stimulus
// process queues the expected per-cycle observation, a monitor pops and compares.
module tb_cpu_sequencer;

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_F    = 3'd1;
  localparam logic [2:0] P_D    = 3'd2;
  localparam logic [2:0] P_E    = 3'd3;
  localparam logic [2:0] P_M    = 3'd4;
  localparam logic [2:0] P_WB   = 3'd5;
  localparam logic [2:0] P_H    = 3'd6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.PC_WIDTH(9)) bus_if ();

  cpu_sequencer #(
    .PC_WIDTH(9),
    .MEM_WAIT(1),
    .HALT_OP (6'b111111)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  typedef struct {
    string       tag;
    logic [2:0]  ph;
    logic [8:0]  pc;
    logic [15:0] ret;
    logic        irl;
    logic        rfw;
    logic        dmw;
    logic        hlt;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    n_checks = 0;
  int    n_pass   = 0;
  string cur_tag  = "init";

  // Drive the decoder-level inputs.
  task automatic dec(input logic [5:0] op, input logic rfw, input logic sel,
                     input logic wr, input logic br, input logic [8:0] dest);
    bus_if.opcode        = op;
    bus_if.rfWriteEnDec  = rfw;
    bus_if.dmemResultSel = sel;
    bus_if.dmemWriteDec  = wr;
    bus_if.branch        = br;
    bus_if.pcDest        = dest;
  endtask

  // Queue what the DUT must show after the coming rising edge, then advance.
  task automatic cyc(input logic [2:0] ph, input logic [8:0] epc,
                     input logic [15:0] ret, input logic dmw);
    exp_t e;
    e.tag = cur_tag;
    e.ph  = ph;
    e.pc  = epc;
    e.ret = ret;
    e.irl = (ph == P_F);
    e.rfw = (ph == P_WB);
    e.hlt = (ph == P_H);
    e.dmw = dmw;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (bus_if.phase === mon_e.ph && bus_if.pc === mon_e.pc &&
          bus_if.retired === mon_e.ret && bus_if.irLoad === mon_e.irl &&
          bus_if.rfWriteEn === mon_e.rfw && bus_if.dmemWriteEn === mon_e.dmw &&
          bus_if.halted === mon_e.hlt) begin
        n_pass++;
      end else begin
        $display("FAIL %s @%0t: got phase=%0d pc=%h ret=%0d ir=%b rf=%b dm=%b h=%b, expected phase=%0d pc=%h ret=%0d ir=%b rf=%b dm=%b h=%b",
                 mon_e.tag, $time, bus_if.phase, bus_if.pc, bus_if.retired,
                 bus_if.irLoad, bus_if.rfWriteEn, bus_if.dmemWriteEn, bus_if.halted,
                 mon_e.ph, mon_e.pc, mon_e.ret, mon_e.irl, mon_e.rfw, mon_e.dmw, mon_e.hlt);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    bus_if.run = 1'b0;
    dec(6'h00, 0, 0, 0, 0, 9'h000);
    @(negedge clk);

    cur_tag = "reset";
    cyc(P_IDLE, 9'h000, 16'd0, 0);
    cyc(P_IDLE, 9'h000, 16'd0, 0);

    // R-type: F D E WB, then pc 0->1, retired 1, back in FETCH.
    rst = 1'b0; bus_if.run = 1'b1;
    dec(6'h00, 1, 0, 0, 0, 9'h000);
    cur_tag = "rtype";
    cyc(P_F,  9'h000, 16'd0, 0);
    cyc(P_D,  9'h000, 16'd0, 0);
    cyc(P_E,  9'h000, 16'd0, 0);
    cyc(P_WB, 9'h000, 16'd0, 0);
    cyc(P_F,  9'h001, 16'd1, 0);

    // lw: MEMORY held two cycles, then WRITEBACK; no dmem write.
    dec(6'h23, 1, 1, 0, 0, 9'h000);
    cur_tag = "lw";
    cyc(P_D,  9'h001, 16'd1, 0);
    cyc(P_E,  9'h001, 16'd1, 0);
    cyc(P_M,  9'h001, 16'd1, 0);
    cyc(P_M,  9'h001, 16'd1, 0);
    cyc(P_WB, 9'h001, 16'd1, 0);
    cyc(P_F,  9'h002, 16'd2, 0);

    // sw: dmemWriteEn only on the first MEMORY cycle, no register write.
    dec(6'h2B, 0, 0, 1, 0, 9'h000);
    cur_tag = "sw";
    cyc(P_D,  9'h002, 16'd2, 0);
    cyc(P_E,  9'h002, 16'd2, 0);
    cyc(P_M,  9'h002, 16'd2, 1);
    cyc(P_M,  9'h002, 16'd2, 0);
    cyc(P_F,  9'h003, 16'd3, 0);

    // Two ALU ops without writeback: 3 cycles each, walk pc up to 5.
    dec(6'h00, 0, 0, 0, 0, 9'h000);
    cur_tag = "alu";
    for (int i = 0; i < 2; i++) begin
      cyc(P_D, 9'h003 + 9'(i), 16'd3 + 16'(i), 0);
      cyc(P_E, 9'h003 + 9'(i), 16'd3 + 16'(i), 0);
      cyc(P_F, 9'h004 + 9'(i), 16'd4 + 16'(i), 0);
    end

    // Branch at pc=5 to 0x1A3, with memory/writeback requests also raised.
    dec(6'h04, 1, 1, 0, 1, 9'h1A3);
    cur_tag = "branch";
    cyc(P_D, 9'h005, 16'd5, 0);
    cyc(P_E, 9'h005, 16'd5, 0);
    cyc(P_F, 9'h1A3, 16'd6, 0);

    // Jump to the top of the address space, then wrap with pc+1.
    dec(6'h02, 0, 0, 0, 1, 9'h1FF);
    cur_tag = "jump_top";
    cyc(P_D, 9'h1A3, 16'd6, 0);
    cyc(P_E, 9'h1A3, 16'd6, 0);
    cyc(P_F, 9'h1FF, 16'd7, 0);
    dec(6'h00, 0, 0, 0, 0, 9'h000);
    cur_tag = "pc_wrap";
    cyc(P_D, 9'h1FF, 16'd7, 0);
    cyc(P_E, 9'h1FF, 16'd7, 0);
    cyc(P_F, 9'h000, 16'd8, 0);

    // lw with run dropped in MEMORY: finishes, then parks in IDLE.
    dec(6'h23, 1, 1, 0, 0, 9'h000);
    cur_tag = "run_drop";
    cyc(P_D,  9'h000, 16'd8, 0);
    cyc(P_E,  9'h000, 16'd8, 0);
    cyc(P_M,  9'h000, 16'd8, 0);
    bus_if.run = 1'b0;
    cyc(P_M,    9'h000, 16'd8, 0);
    cyc(P_WB,   9'h000, 16'd8, 0);
    cyc(P_IDLE, 9'h001, 16'd9, 0);
    cyc(P_IDLE, 9'h001, 16'd9, 0);

    // HALT opcode: absorbing for 20 cycles with run=1 and noisy decoder inputs.
    bus_if.run = 1'b1;
    dec(6'h3F, 0, 0, 0, 0, 9'h000);
    cur_tag = "halt";
    cyc(P_F, 9'h001, 16'd9, 0);
    cyc(P_D, 9'h001, 16'd9, 0);
    dec(6'h3F, 1, 0, 1, 1, 9'h055);
    for (int i = 0; i < 20; i++) cyc(P_H, 9'h001, 16'd9, 0);

    // rst leaves HALT.
    rst = 1'b1;
    cur_tag = "halt_rst";
    cyc(P_IDLE, 9'h000, 16'd0, 0);
    rst = 1'b0; bus_if.run = 1'b0;
    dec(6'h00, 0, 0, 0, 0, 9'h000);
    cyc(P_IDLE, 9'h000, 16'd0, 0);

    // rst asserted in WRITEBACK: IDLE next, no further register write.
    bus_if.run = 1'b1;
    dec(6'h00, 1, 0, 0, 0, 9'h000);
    cur_tag = "wb_rst";
    cyc(P_F,  9'h000, 16'd0, 0);
    cyc(P_D,  9'h000, 16'd0, 0);
    cyc(P_E,  9'h000, 16'd0, 0);
    cyc(P_WB, 9'h000, 16'd0, 0);
    rst = 1'b1;
    cyc(P_IDLE, 9'h000, 16'd0, 0);
    rst = 1'b0; bus_if.run = 1'b0;
    cyc(P_IDLE, 9'h000, 16'd0, 0);
    cyc(P_IDLE, 9'h000, 16'd0, 0);

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM that sequences the single-datapath CPU one instruction at a time. It owns the program counter and the instruction-register load strobe. It turns the decoder's level controls into one-cycle phase strobes: register-file write, data-memory write and PC update. The decoder and ALU stay combinational; this block decides when their results are committed.

Parameters:
PC_WIDTH, 9, width of pc and pcDest (instruction-memory word address)
MEM_WAIT, 1, extra cycles spent in MEMORY after the first (0..7)
HALT_OP, 6'b111111, opcode that stops the sequencer

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
run  input  1  level; allows a new instruction to start; sampled only at instruction boundaries
opcode  input  6  instruction[31:26] from the instruction register
rfWriteEnDec  input  1  decoder's register-write request
dmemResultSel  input  1  decoder load indicator (lw)
dmemWriteDec  input  1  decoder store indicator (sw)
branch  input  1  decoder branch/jump-taken
pcDest  input  PC_WIDTH  target PC when branch=1
pc  output  PC_WIDTH  current program counter
irLoad  output  1  instruction-register load strobe
rfWriteEn  output  1  register-file write strobe
dmemWriteEn  output  1  data-memory write strobe
phase  output  3  current state encoding
halted  output  1  high while in HALT
retired  output  16  completed-instruction count, saturating

Behaviour:
- Reset (rst=1 at an edge): state IDLE, pc=0, retired=0. All strobes and halted are 0, phase=0. rst has priority over every other event in every state, including mid-instruction and HALT.
- State encodings (phase): IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6.
- Strobes are Moore outputs and depend on the state register only:
  - irLoad=1 only in FETCH.
  - rfWriteEn=1 only in WRITEBACK.
  - dmemWriteEn=1 only on the first MEMORY cycle, and only when dmemWriteDec=1.
  - halted=1 only in HALT.
- Transitions:
  - IDLE: run=1 -> FETCH; otherwise stay.
  - FETCH: -> DECODE. Always one cycle.
  - DECODE: opcode==HALT_OP -> HALT; else -> EXECUTE.
  - EXECUTE:
    - branch=1 -> pc<=pcDest, instruction complete.
    - else dmemResultSel|dmemWriteDec -> MEMORY, wait counter loaded with MEW_WAIT.
    - else rfWriteEnDec -> WRITEBACK.
    - else pc<=pc+1, instruction complete.
    - Branch has priority over memory, and memory over writeback.
  - MEMORY: stay while wait counter !=0, decrementing each cycle. At 0: load -> WRITEBACK; store -> pc<=pc+1, instruction complete.
  - WRITEBACK: pc<=pc+1, instruction complete.
  - HALT: absorbing; only rst leaves it. pc stays frozen and retired is not incremented.
- Instruction complete: retired<=retired+1, saturating at 16'hFFFF. Next state is FETCH if run=1, else IDLE.
- pc arithmetic is modulo 2^PC_WIDTH: 511+1 -> 0 at the default width.
- run deasserted mid-instruction does not abort; the current instruction finishes.
- Cycle counts from FETCH entry to completion:
  - ALU, no write: 3.
  - Branch: 3.
  - R-type/addi: 4.
  - Store: 4+MEW_WAIT.
  - Load: 5+MEW_WAIT.
- Decoder inputs are sampled only in EXECUTE and MEMORY. They must be stable from DECODE through completion.

Test Plan:
- Reset then run=1, opcode=000000, rfWriteEnDec=1 -> phases 1,2,3,5, rfWriteEn high exactly 1 cycle, pc 0->1, retired=1, back in FETCH.
- lw with MEM_WAIT=1 (dmemResultSel=1, rfWriteEnDec=1) -> MEMORY held 2 cycles, then WRITEBACK, 6 cycles total, dmemWriteEn never high.
- sw with MEM_WAIT=1 (dmemWriteDec=1) -> dmemWriteEn high only on first MEMORY cycle, rfWriteEn stays 0, pc+1.
- branch=1 with pcDest=9'h1A3 at pc=5 -> pc=0x1A3 after EXECUTE, 3 cycles, no write strobes.
- pc=511, non-branch ALU op -> pc wraps to 0. opcode=111111 -> HALT, halted=1, pc/retired frozen for 20 cycles despite run=1, rst returns to IDLE with pc=0.
- run dropped during MEMORY -> instruction completes, state IDLE. rst asserted in WRITEBACK -> next cycle IDLE with no further rfWriteEn.
